// File: rtl/dmg_timer_cnt.sv
// Prescaled reload counter: a free-running divider, a selectable divider tap
// feeding a counter, and a modulo reload that lands two edges after overflow.
module dmg_timer_cnt #(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned TAP0      = 9,
    parameter int unsigned TAP1      = 3,
    parameter int unsigned TAP2      = 5,
    parameter int unsigned TAP3      = 7
) (
    input  logic                 clk,
    input  logic                 res,
    input  logic                 div_rst,
    output logic [DIV_WIDTH-1:0] div_q,
    input  logic                 cnt_ena,
    input  logic [1:0]           tap_sel,
    input  logic                 cnt_wr,
    input  logic [CNT_WIDTH-1:0] cnt_d,
    input  logic                 mod_wr,
    input  logic [CNT_WIDTH-1:0] mod_d,
    output logic [CNT_WIDTH-1:0] cnt_q,
    output logic [CNT_WIDTH-1:0] mod_q,
    output logic                 ovf_irq,
    output logic                 reload_busy
);

    localparam int unsigned IW = (DIV_WIDTH > 1) ? $clog2(DIV_WIDTH) : 1;
    localparam logic [IW-1:0] TAP0_IDX = IW'(TAP0);
    localparam logic [IW-1:0] TAP1_IDX = IW'(TAP1);
    localparam logic [IW-1:0] TAP2_IDX = IW'(TAP2);
    localparam logic [IW-1:0] TAP3_IDX = IW'(TAP3);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        OVF    = 2'd1,
        RELOAD = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 tap_bit;
    logic                 tick;
    logic                 tick_prev;
    logic                 inc;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            div_q <= '0;
        end else if (div_rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_WIDTH'(1);
        end
    end

    always_comb begin
        tap_bit = 1'b0;
        case (tap_sel)
            2'd0:    tap_bit = div_q[TAP0_IDX];
            2'd1:    tap_bit = div_q[TAP1_IDX];
            2'd2:    tap_bit = div_q[TAP2_IDX];
            default: tap_bit = div_q[TAP3_IDX];
        endcase
    end

    // Any falling edge of the gated tap counts, including ones caused by
    // div_rst, cnt_ena dropping or a tap_sel change.
    assign tick = cnt_ena & tap_bit;
    assign inc  = tick_prev & ~tick;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            tick_prev <= 1'b0;
        end else begin
            tick_prev <= tick;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            mod_q <= '0;
        end else if (mod_wr) begin
            mod_q <= mod_d;
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= RUN;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        case (state)
            RUN: begin
                if (cnt_wr) begin
                    cnt_nxt = cnt_d;
                end else if (inc) begin
                    if (cnt_q == CNT_MAX) begin
                        cnt_nxt   = '0;
                        state_nxt = OVF;
                    end else begin
                        cnt_nxt = cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            OVF: begin
                // A write during the zero cycle wins and cancels the reload.
                if (cnt_wr) begin
                    cnt_nxt   = cnt_d;
                    state_nxt = RUN;
                end else begin
                    cnt_nxt   = mod_wr ? mod_d : mod_q;
                    state_nxt = RELOAD;
                end
            end
            RELOAD: begin
                if (mod_wr) begin
                    cnt_nxt = mod_d;
                end
                state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_comb begin
        ovf_irq     = 1'b0;
        reload_busy = 1'b0;
        if (state == RELOAD) begin
            ovf_irq = 1'b1;
        end
        if (state != RUN) begin
            reload_busy = 1'b1;
        end
    end

endmodule

// File: tb/tb_dmg_timer_cnt.sv
// Bench for dmg_timer_cnt: directed vector table, hand-written corner
// sequences, and random stimulus against a cycle-level reference model.
module tb_dmg_timer_cnt;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 16;

    logic          clk;
    logic          res;
    logic          div_rst;
    logic [DW-1:0] div_q;
    logic          cnt_ena;
    logic [1:0]    tap_sel;
    logic          cnt_wr;
    logic [CW-1:0] cnt_d;
    logic          mod_wr;
    logic [CW-1:0] mod_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] mod_q;
    logic          ovf_irq;
    logic          reload_busy;

    int n_checks = 0;
    int n_fail   = 0;

    dmg_timer_cnt #(
        .CNT_WIDTH(CW),
        .DIV_WIDTH(DW),
        .TAP0(9),
        .TAP1(3),
        .TAP2(5),
        .TAP3(7)
    ) dut (
        .clk(clk),
        .res(res),
        .div_rst(div_rst),
        .div_q(div_q),
        .cnt_ena(cnt_ena),
        .tap_sel(tap_sel),
        .cnt_wr(cnt_wr),
        .cnt_d(cnt_d),
        .mod_wr(mod_wr),
        .mod_d(mod_d),
        .cnt_q(cnt_q),
        .mod_q(mod_q),
        .ovf_irq(ovf_irq),
        .reload_busy(reload_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned reps;
        logic        d_rst;
        logic        ena;
        logic        cwr;
        logic [7:0]  cd;
        logic        mwr;
        logic [7:0]  md;
        logic [7:0]  e_cnt;
        logic [7:0]  e_mod;
        logic        e_irq;
        logic        e_busy;
    } vec_t;

    vec_t tbl[21];

    // Reference model: phase counts edges since the overflow (0 = counting).
    int unsigned taps[4] = '{9, 3, 5, 7};
    int unsigned m_div;
    bit          m_prev;
    int unsigned m_cnt;
    int unsigned m_mod;
    int unsigned m_phase;

    function automatic vec_t mk(int unsigned reps, logic d_rst, logic ena,
                                logic cwr, logic [7:0] cd, logic mwr, logic [7:0] md,
                                logic [7:0] e_cnt, logic [7:0] e_mod, logic e_irq, logic e_busy);
        vec_t v;
        v.reps = reps; v.d_rst = d_rst; v.ena = ena; v.cwr = cwr; v.cd = cd;
        v.mwr = mwr; v.md = md; v.e_cnt = e_cnt; v.e_mod = e_mod;
        v.e_irq = e_irq; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        div_rst = 1'b0; cnt_ena = 1'b0; tap_sel = 2'd1;
        cnt_wr = 1'b0; cnt_d = '0; mod_wr = 1'b0; mod_d = '0;
    endtask

    task automatic model_reset();
        m_div = 0; m_prev = 0; m_cnt = 0; m_mod = 0; m_phase = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        res = 1'b1;
        @(posedge clk);
        #3;
        res = 1'b0;
        model_reset();
    endtask

    task automatic model_step();
        bit          tick;
        bit          inc;
        int unsigned old_mod;
        tick    = cnt_ena && (((m_div >> taps[tap_sel]) & 1) == 1);
        inc     = m_prev && !tick;
        old_mod = m_mod;
        m_div   = div_rst ? 0 : (m_div + 1) % (1 << DW);
        m_prev  = tick;
        if (mod_wr) m_mod = mod_d;
        if (m_phase == 0) begin
            if (cnt_wr) begin
                m_cnt = cnt_d;
            end else if (inc) begin
                if (m_cnt == (1 << CW) - 1) m_phase = 1;
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
        end else if (m_phase == 1) begin
            if (cnt_wr) begin
                m_cnt   = cnt_d;
                m_phase = 0;
            end else begin
                m_cnt   = mod_wr ? int'(mod_d) : old_mod;
                m_phase = 2;
            end
        end else begin
            if (mod_wr) m_cnt = mod_d;
            m_phase = 0;
        end
    endtask

    task automatic step_m();
        @(posedge clk);
        model_step();
        #1;
        check("rnd_div",  32'(div_q),       m_div);
        check("rnd_cnt",  32'(cnt_q),       m_cnt);
        check("rnd_mod",  32'(mod_q),       m_mod);
        check("rnd_irq",  32'(ovf_irq),     32'(m_phase == 2));
        check("rnd_busy", 32'(reload_busy), 32'(m_phase != 0));
    endtask

    initial begin
        clear_inputs();
        res = 1'b1;
        #12;
        check("rst_div",  32'(div_q), 0);
        check("rst_cnt",  32'(cnt_q), 0);
        check("rst_mod",  32'(mod_q), 0);
        check("rst_irq",  32'(ovf_irq), 0);
        check("rst_busy", 32'(reload_busy), 0);

        // Tap 3 after a divider clear: falling edges land on edges 17, 33, 49, 65, 81.
        tbl[0]  = mk(1,  1, 0, 1, 8'hFF, 1, 8'hFE, 8'hFF, 8'hFE, 0, 0);
        tbl[1]  = mk(16, 0, 1, 0, 8'h00, 0, 8'h00, 8'hFF, 8'hFE, 0, 0);
        tbl[2]  = mk(1,  0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'hFE, 0, 1);
        tbl[3]  = mk(1,  0, 1, 0, 8'h00, 0, 8'h00, 8'hFE, 8'hFE, 1, 1);
        tbl[4]  = mk(1,  0, 1, 0, 8'h00, 0, 8'h00, 8'hFE, 8'hFE, 0, 0);
        tbl[5]  = mk(13, 0, 1, 0, 8'h00, 0, 8'h00, 8'hFE, 8'hFE, 0, 0);
        tbl[6]  = mk(1,  0, 1, 0, 8'h00, 0, 8'h00, 8'hFF, 8'hFE, 0, 0);
        tbl[7]  = mk(15, 0, 1, 0, 8'h00, 0, 8'h00, 8'hFF, 8'hFE, 0, 0);
        tbl[8]  = mk(1,  0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'hFE, 0, 1);
        tbl[9]  = mk(1,  0, 1, 1, 8'h42, 0, 8'h00, 8'h42, 8'hFE, 0, 0);
        tbl[10] = mk(1,  0, 1, 0, 8'h00, 0, 8'h00, 8'h42, 8'hFE, 0, 0);
        tbl[11] = mk(1,  0, 1, 1, 8'hFF, 0, 8'h00, 8'hFF, 8'hFE, 0, 0);
        tbl[12] = mk(12, 0, 1, 0, 8'h00, 0, 8'h00, 8'hFF, 8'hFE, 0, 0);
        tbl[13] = mk(1,  0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'hFE, 0, 1);
        tbl[14] = mk(1,  0, 1, 0, 8'h00, 0, 8'h00, 8'hFE, 8'hFE, 1, 1);
        tbl[15] = mk(1,  0, 1, 1, 8'h55, 0, 8'h00, 8'hFE, 8'hFE, 0, 0);
        tbl[16] = mk(1,  0, 1, 1, 8'hFF, 1, 8'h10, 8'hFF, 8'h10, 0, 0);
        tbl[17] = mk(12, 0, 1, 0, 8'h00, 0, 8'h00, 8'hFF, 8'h10, 0, 0);
        tbl[18] = mk(1,  0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 8'h10, 0, 1);
        tbl[19] = mk(1,  0, 1, 0, 8'h00, 0, 8'h00, 8'h10, 8'h10, 1, 1);
        tbl[20] = mk(1,  0, 1, 0, 8'h00, 1, 8'h80, 8'h80, 8'h80, 0, 0);

        do_reset();
        for (int i = 0; i < 21; i++) begin
            div_rst = tbl[i].d_rst; cnt_ena = tbl[i].ena; tap_sel = 2'd1;
            cnt_wr = tbl[i].cwr; cnt_d = tbl[i].cd;
            mod_wr = tbl[i].mwr; mod_d = tbl[i].md;
            for (int r = 0; r < int'(tbl[i].reps); r++) begin
                cyc();
                check($sformatf("vec%0d_cnt", i),  32'(cnt_q),       32'(tbl[i].e_cnt));
                check($sformatf("vec%0d_mod", i),  32'(mod_q),       32'(tbl[i].e_mod));
                check($sformatf("vec%0d_irq", i),  32'(ovf_irq),     32'(tbl[i].e_irq));
                check($sformatf("vec%0d_busy", i), 32'(reload_busy), 32'(tbl[i].e_busy));
            end
        end

        // Falling tap edge forced by div_rst, then by cnt_ena dropping.
        do_reset();
        tap_sel = 2'd0;
        cnt_ena = 1'b1;
        for (int i = 0; i < 600 && !div_q[9]; i++) cyc();
        check("t5_tap_high", 32'(div_q[9]), 1);
        cyc();
        div_rst = 1'b1;
        cyc();
        div_rst = 1'b0;
        check("t5_div_clr", 32'(div_q), 0);
        check("t5_cnt_pre", 32'(cnt_q), 0);
        cyc();
        check("t5_cnt_inc", 32'(cnt_q), 1);
        repeat (10) cyc();
        check("t5_cnt_once", 32'(cnt_q), 1);
        for (int i = 0; i < 600 && !div_q[9]; i++) cyc();
        check("t5_tap_high2", 32'(div_q[9]), 1);
        cyc();
        check("t5_cnt_pre2", 32'(cnt_q), 1);
        cnt_ena = 1'b0;
        cyc();
        check("t5_ena_inc", 32'(cnt_q), 2);
        repeat (10) cyc();
        check("t5_ena_once", 32'(cnt_q), 2);

        // Asynchronous reset while in the zero (overflow) cycle.
        do_reset();
        mod_wr = 1'b1; mod_d = 8'h33; cnt_wr = 1'b1; cnt_d = 8'hFF;
        cyc();
        mod_wr = 1'b0; cnt_wr = 1'b0;
        cnt_ena = 1'b1; tap_sel = 2'd1;
        for (int i = 0; i < 40 && !reload_busy; i++) cyc();
        check("t6_in_ovf", 32'(reload_busy), 1);
        check("t6_ovf_cnt", 32'(cnt_q), 0);
        #2;
        res = 1'b1;
        #1;
        check("t6_async_div",  32'(div_q), 0);
        check("t6_async_mod",  32'(mod_q), 0);
        check("t6_async_irq",  32'(ovf_irq), 0);
        check("t6_async_busy", 32'(reload_busy), 0);
        #2;
        res = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            check("t6_no_irq", 32'(ovf_irq), 0);
            check("t6_no_busy", 32'(reload_busy), 0);
        end
        check("t6_cnt_hold", 32'(cnt_q), 0);
        cyc();
        check("t6_cnt_resume", 32'(cnt_q), 1);

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            div_rst = ($urandom_range(63) == 0);
            cnt_ena = ($urandom_range(3) != 0);
            if ($urandom_range(31) == 0) tap_sel = 2'($urandom_range(3));
            cnt_wr  = ($urandom_range(47) == 0);
            cnt_d   = ($urandom_range(1) == 1) ? 8'(8'hF8 + $urandom_range(7)) : 8'($urandom_range(255));
            mod_wr  = ($urandom_range(15) == 0);
            mod_d   = 8'($urandom_range(255));
            step_m();
        end

        // Divider wrap at all-ones.
        do_reset();
        repeat ((1 << DW) - 1) cyc();
        check("div_max", 32'(div_q), (1 << DW) - 1);
        cyc();
        check("div_wrap", 32'(div_q), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
